// File: rtl/led_fader.sv
// Multi-channel LED fader: per-channel linear ramp of brightness toward an on/off target,
// rendered as PWM. Define LED_FADER_GAMMA_EN for square-law (perceptual) dimming.
module led_fader #(
    parameter int unsigned CH        = 5,
    parameter int unsigned PWM_BITS  = 8,
    parameter int unsigned STEP_LOG2 = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] led_in,
    output logic [CH-1:0] led_out,
    output logic          busy
);

    localparam logic [PWM_BITS-1:0] MaxBright = '1;
    localparam logic [PWM_BITS-1:0] MinBright = '0;

    typedef enum logic [1:0] {StOff, StRise, StOn, StFall} state_e;

    logic [CH-1:0]        tgt_q;
    logic [STEP_LOG2-1:0] presc_q, presc_d;
    logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0]  bright_q [CH];
    logic [PWM_BITS-1:0]  bright_d [CH];
    state_e               state_q  [CH];
    state_e               state_d  [CH];
    logic [PWM_BITS-1:0]  level    [CH];
    logic [CH-1:0]        led_out_q, led_out_d;
    logic                 busy_q, busy_d;
    logic                 tick;

    assign tick = &presc_q;

`ifdef LED_FADER_GAMMA_EN
    function automatic logic [PWM_BITS-1:0] gamma(input logic [PWM_BITS-1:0] b);
        logic [2*PWM_BITS-1:0] sq;
        sq = (2*PWM_BITS)'(b) * (2*PWM_BITS)'(b);
        return PWM_BITS'(sq >> PWM_BITS);
    endfunction

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            level[i] = gamma(bright_q[i]);
        end
    end
`else
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            level[i] = bright_q[i];
        end
    end
`endif

    always_comb begin
        presc_d   = presc_q + 1'b1;
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        busy_d    = 1'b0;
        led_out_d = '0;
        for (int i = 0; i < CH; i++) begin
            bright_d[i] = bright_q[i];
            state_d[i]  = state_q[i];

            if (state_q[i] == StRise || state_q[i] == StFall) begin
                busy_d = 1'b1;
            end

            if (bright_q[i] == MaxBright) begin
                led_out_d[i] = 1'b1;
            end else if (bright_q[i] == MinBright) begin
                led_out_d[i] = 1'b0;
            end else begin
                led_out_d[i] = (pwm_cnt_q < level[i]);
            end

            case (state_q[i])
                StOff: if (tgt_q[i]) state_d[i] = StRise;
                StOn:  if (!tgt_q[i]) state_d[i] = StFall;
                StRise, StFall: begin
                    // Direction always follows the current target, so a reversal takes
                    // effect on the very tick it coincides with.
                    if (tgt_q[i]) begin
                        state_d[i] = StRise;
                        if (tick) begin
                            if (bright_q[i] != MaxBright) bright_d[i] = bright_q[i] + 1'b1;
                            if (bright_q[i] >= MaxBright - 1'b1) state_d[i] = StOn;
                        end
                    end else begin
                        state_d[i] = StFall;
                        if (tick) begin
                            if (bright_q[i] != MinBright) bright_d[i] = bright_q[i] - 1'b1;
                            if (bright_q[i] <= MinBright + 1'b1) state_d[i] = StOff;
                        end
                    end
                end
                default: state_d[i] = StOff;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_q     <= '0;
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            led_out_q <= '0;
            busy_q    <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                bright_q[i] <= '0;
                state_q[i]  <= StOff;
            end
        end else begin
            tgt_q     <= led_in;
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_out_q <= led_out_d;
            busy_q    <= busy_d;
            for (int i = 0; i < CH; i++) begin
                bright_q[i] <= bright_d[i];
                state_q[i]  <= state_d[i];
            end
        end
    end

    assign led_out = led_out_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// Self-checking bench for led_fader: cycle-level comparison against a target-seeking
// brightness model, plus a duty-cycle measurement on a slow-tick instance.
module tb_led_fader;

    localparam int CH       = 5;
    localparam int MAXV     = 255;
    localparam int TICK_PER = 4;

    logic          clk;
    logic          rst;
    logic [CH-1:0] led_in;
    logic [CH-1:0] led_out;
    logic          busy;
    logic [0:0]    led_in2;
    logic [0:0]    led_out2;
    logic          busy2;

    int checks;
    int errors;

    led_fader #(.CH(CH), .PWM_BITS(8), .STEP_LOG2(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .led_in (led_in),
        .led_out(led_out),
        .busy   (busy)
    );

    // Tick every 256 cycles so a brightness level holds for a whole PWM period.
    led_fader #(.CH(1), .PWM_BITS(8), .STEP_LOG2(8)) dut_slow (
        .clk    (clk),
        .rst    (rst),
        .led_in (led_in2),
        .led_out(led_out2),
        .busy   (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each channel either rests at an end point or moves one step toward its
    // target's end point per tick; output is the PWM rendering of the brightness.
    logic [CH-1:0] m_tgt_q, m_tgt_d;
    int            m_presc_q, m_presc_d;
    int            m_pwm_q, m_pwm_d;
    int            m_b_q [CH];
    int            m_b_d [CH];
    logic [CH-1:0] m_mov_q, m_mov_d;
    logic [CH-1:0] m_rest_q, m_rest_d;
    logic [CH-1:0] m_led_q, m_led_d;
    logic          m_busy_q, m_busy_d;

    function automatic int lvl(input int b);
`ifdef LED_FADER_GAMMA_EN
        return (b * b) / 256;
`else
        return b;
`endif
    endfunction

    always_comb begin
        m_tgt_d   = led_in;
        m_presc_d = (m_presc_q + 1) % TICK_PER;
        m_pwm_d   = (m_pwm_q + 1) % 256;
        m_busy_d  = (m_mov_q != '0);
        m_led_d   = '0;
        m_mov_d   = m_mov_q;
        m_rest_d  = m_rest_q;
        for (int i = 0; i < CH; i++) begin
            m_b_d[i] = m_b_q[i];
            if (m_b_q[i] == MAXV) m_led_d[i] = 1'b1;
            else if (m_b_q[i] == 0) m_led_d[i] = 1'b0;
            else m_led_d[i] = (m_pwm_q < lvl(m_b_q[i]));
            if (!m_mov_q[i]) begin
                if (m_tgt_q[i] != m_rest_q[i]) m_mov_d[i] = 1'b1;
            end else if (m_presc_q == TICK_PER - 1) begin
                if (m_tgt_q[i] && m_b_q[i] < MAXV) m_b_d[i] = m_b_q[i] + 1;
                else if (!m_tgt_q[i] && m_b_q[i] > 0) m_b_d[i] = m_b_q[i] - 1;
                if (m_b_d[i] == (m_tgt_q[i] ? MAXV : 0)) begin
                    m_mov_d[i]  = 1'b0;
                    m_rest_d[i] = m_tgt_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tgt_q   <= '0;
            m_presc_q <= 0;
            m_pwm_q   <= 0;
            m_mov_q   <= '0;
            m_rest_q  <= '0;
            m_led_q   <= '0;
            m_busy_q  <= 1'b0;
            for (int i = 0; i < CH; i++) m_b_q[i] <= 0;
        end else begin
            m_tgt_q   <= m_tgt_d;
            m_presc_q <= m_presc_d;
            m_pwm_q   <= m_pwm_d;
            m_mov_q   <= m_mov_d;
            m_rest_q  <= m_rest_d;
            m_led_q   <= m_led_d;
            m_busy_q  <= m_busy_d;
            for (int i = 0; i < CH; i++) m_b_q[i] <= m_b_d[i];
        end
    end

    task automatic do_reset(input logic [CH-1:0] init);
        rst     = 1'b1;
        led_in  = init;
        led_in2 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        led_in = 5'($urandom);
        @(negedge clk);
        checks++;
        if (led_out !== '0) begin
            errors++;
            $display("FAIL reset_led_out got %b exp 00000", led_out);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b exp 0", busy);
        end
        checks++;
        if (led_out2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_led_out2 got %b exp 0", led_out2);
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (led_out !== m_led_q || busy !== m_busy_q) begin
                errors++;
                $display("FAIL post_reset c=%0d got %b/%b exp %b/%b", c, led_out, busy,
                         m_led_q, m_busy_q);
            end
        end
    endtask

    task automatic test_rise_full();
        int busy_at;
        busy_at = -1;
        do_reset(5'b10000);
        for (int c = 1; c <= 1100; c++) begin
            @(negedge clk);
            if (busy_at < 0 && busy === 1'b1) busy_at = c;
            checks++;
            if (led_out !== m_led_q || busy !== m_busy_q) begin
                errors++;
                $display("FAIL rise c=%0d got %b/%b exp %b/%b", c, led_out, busy,
                         m_led_q, m_busy_q);
            end
        end
        checks++;
        if (busy_at < 1 || busy_at > 3) begin
            errors++;
            $display("FAIL rise_busy_latency got %0d exp 1..3", busy_at);
        end
        for (int c = 0; c < 256; c++) begin
            @(negedge clk);
            checks++;
            if (led_out !== 5'b10000 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rise_full_on c=%0d got %b/%b exp 10000/0", c, led_out, busy);
            end
        end
    endtask

    task automatic test_fall();
        do_reset('0);
        led_in = 5'b00010;
        for (int c = 0; c < 402; c++) begin
            @(negedge clk);
            checks++;
            if (led_out !== m_led_q || busy !== m_busy_q) begin
                errors++;
                $display("FAIL fall_up c=%0d got %b/%b exp %b/%b", c, led_out, busy,
                         m_led_q, m_busy_q);
            end
        end
        led_in = '0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            checks++;
            if (led_out !== m_led_q || busy !== m_busy_q) begin
                errors++;
                $display("FAIL fall_down c=%0d got %b/%b exp %b/%b", c, led_out, busy,
                         m_led_q, m_busy_q);
            end
        end
        checks++;
        if (busy !== 1'b0 || led_out !== '0) begin
            errors++;
            $display("FAIL fall_end got %b/%b exp 00000/0", led_out, busy);
        end
    endtask

    task automatic test_glitch();
        do_reset('0);
        repeat (5) @(negedge clk);
        led_in = 5'b00100;
        @(negedge clk);
        led_in = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (led_out !== '0 || busy !== m_busy_q) begin
                errors++;
                $display("FAIL glitch c=%0d got %b/%b exp 00000/%b", c, led_out, busy,
                         m_busy_q);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_idle got %b exp 0", busy);
        end
    endtask

    task automatic test_async_reset();
        do_reset('0);
        led_in = 5'b01011;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            checks++;
            if (led_out !== m_led_q || busy !== m_busy_q) begin
                errors++;
                $display("FAIL async_pre c=%0d got %b/%b exp %b/%b", c, led_out, busy,
                         m_led_q, m_busy_q);
            end
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (led_out !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got %b/%b exp 00000/0", led_out, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            checks++;
            if (led_out !== m_led_q || busy !== m_busy_q) begin
                errors++;
                $display("FAIL async_post c=%0d got %b/%b exp %b/%b", c, led_out, busy,
                         m_led_q, m_busy_q);
            end
        end
    endtask

    task automatic test_random();
        do_reset('0);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            checks++;
            if (led_out !== m_led_q || busy !== m_busy_q) begin
                errors++;
                $display("FAIL random c=%0d got %b/%b exp %b/%b", c, led_out, busy,
                         m_led_q, m_busy_q);
            end
            if ($urandom_range(0, 29) == 0) led_in = 5'($urandom);
        end
    endtask

    task automatic test_pwm_duty();
        int ones;
        int exp_ones;
        ones = 0;
`ifdef LED_FADER_GAMMA_EN
        exp_ones = 16;
`else
        exp_ones = 64;
`endif
        rst     = 1'b1;
        led_in  = '0;
        led_in2 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        // Brightness is 64 from edge 16384 to 16639; output lags one cycle.
        for (int k = 1; k <= 16640; k++) begin
            @(negedge clk);
            if (k >= 16385 && led_out2 === 1'b1) ones++;
        end
        checks++;
        if (ones !== exp_ones) begin
            errors++;
            $display("FAIL pwm_duty got %0d exp %0d", ones, exp_ones);
        end
        checks++;
        if (busy2 !== 1'b1) begin
            errors++;
            $display("FAIL pwm_busy got %b exp 1", busy2);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        led_in  = '0;
        led_in2 = 1'b0;
        test_reset();
        test_rise_full();
        test_fall();
        test_glitch();
        test_async_reset();
        test_random();
        test_pwm_duty();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
